fpu_issue_scoreboard: RTL and testbench



---
 rtl/fpu_issue_pkg.sv | 22 ++
 rtl/fpu_issue_scoreboard_if.sv | 60 ++++++
 rtl/fpu_tag_alloc.sv | 57 +++++
 rtl/fpu_issue_scoreboard.sv | 150 +++++++++++++++
 tb/tb_fpu_issue_scoreboard.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_issue_pkg.sv
// Shared types, reset constants and sizing helpers for the FPU issue scoreboard.
package fpu_issue_pkg;

    // Tag index width; a single tag still needs one bit to address it.
    function automatic int tag_width(input int max_out);
        return (max_out <= 2) ? 1 : $clog2(max_out);
    endfunction

    // Fixed-width control part of an issue entry (op and tag widths are per-instance).
    typedef struct packed {
        logic [2:0] rnd;
        logic [2:0] pre;
        logic       fd_en;
    } iss_ctrl_t;

    localparam iss_ctrl_t ISS_CTRL_RST = '{rnd: 3'd0, pre: 3'd0, fd_en: 1'b0};

    // Scoreboard reset values: every tag free, no destination recorded.
    localparam logic TAG_FREE = 1'b0;
    localparam logic FD_RST   = 1'b0;

endpackage

// File: rtl/fpu_issue_scoreboard_if.sv
// Decoder, issue, writeback and regfile signals of the FPU issue stage.
interface fpu_issue_scoreboard_if #(
    parameter int FPLEN   = 16,
    parameter int NUM_FPR = 32,
    parameter int MAX_OUT = 4,
    parameter int OPW     = 24
);
    import fpu_issue_pkg::*;

    localparam int AW = $clog2(NUM_FPR);
    localparam int TW = tag_width(MAX_OUT);

    // decoder side
    logic               dec_valid;
    logic               dec_ready;
    logic [2:0]         dec_src_en;
    logic [AW-1:0]      dec_fs1;
    logic [AW-1:0]      dec_fs2;
    logic [AW-1:0]      dec_fs3;
    logic               dec_fd_en;
    logic [AW-1:0]      dec_fd;
    logic [OPW-1:0]     dec_op;
    logic [2:0]         dec_rnd;
    logic [2:0]         dec_pre;
    // execution-unit side
    logic               iss_valid;
    logic               iss_ready;
    logic [OPW-1:0]     iss_op;
    logic [2:0]         iss_rnd;
    logic [2:0]         iss_pre;
    logic               iss_fd_en;
    logic [TW-1:0]      iss_tag;
    logic               wb_valid;
    logic [TW-1:0]      wb_tag;
    logic [FPLEN-1:0]   wb_data;
    // register file write port
    logic               fpr_wen;
    logic [AW-1:0]      fpr_waddr;
    logic [FPLEN-1:0]   fpr_wdata;
    // control / status
    logic               flush;
    logic               wb_err;
    logic [TW:0]        outstanding;
    logic [NUM_FPR-1:0] busy_vec;

    modport slave (
        input  dec_valid, dec_src_en, dec_fs1, dec_fs2, dec_fs3, dec_fd_en, dec_fd,
               dec_op, dec_rnd, dec_pre, iss_ready, wb_valid, wb_tag, wb_data, flush,
        output dec_ready, iss_valid, iss_op, iss_rnd, iss_pre, iss_fd_en, iss_tag,
               fpr_wen, fpr_waddr, fpr_wdata, wb_err, outstanding, busy_vec
    );

    modport master (
        output dec_valid, dec_src_en, dec_fs1, dec_fs2, dec_fs3, dec_fd_en, dec_fd,
               dec_op, dec_rnd, dec_pre, iss_ready, wb_valid, wb_tag, wb_data, flush,
        input  dec_ready, iss_valid, iss_op, iss_rnd, iss_pre, iss_fd_en, iss_tag,
               fpr_wen, fpr_waddr, fpr_wdata, wb_err, outstanding, busy_vec
    );

endinterface

// File: rtl/fpu_tag_alloc.sv
// Writeback-tag free list: lowest-index allocation, mask-based release, live count.
module fpu_tag_alloc
    import fpu_issue_pkg::*;
#(
    parameter int MAX_OUT = 4,
    parameter int TW      = tag_width(MAX_OUT)
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               i_alloc,
    input  logic [MAX_OUT-1:0] i_free_mask,
    output logic               o_avail,
    output logic [TW-1:0]      o_tag,
    output logic [MAX_OUT-1:0] o_alloc_vec,
    output logic [TW:0]        o_count
);

    localparam int CW = TW + 1;

    logic [MAX_OUT-1:0] r_alloc;
    logic [MAX_OUT-1:0] w_set;
    logic [TW-1:0]      w_tag;
    logic [CW-1:0]      w_count;

    // Priority-encode the lowest free tag from the pre-edge free list.
    always_comb begin
        // NOTE: combinational blocks assign a default first and use blocking '=';
        // every path then drives w_tag, so no latch is inferred.
        w_tag = '0;
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            if (!r_alloc[i]) w_tag = TW'(i);
        end
    end

    // Population count of allocated tags.
    always_comb begin
        w_count = '0;
        for (int i = 0; i < MAX_OUT; i++) begin
            w_count = w_count + CW'(r_alloc[i]);
        end
    end

    assign w_set = i_alloc ? (MAX_OUT'(1) << w_tag) : '0;

    // Free-list bitmap: release first, then claim the chosen tag.
    always_ff @(posedge clk or negedge rst_l) begin
        // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
        if (!rst_l) r_alloc <= {MAX_OUT{TAG_FREE}};
        else        r_alloc <= (r_alloc & ~i_free_mask) | w_set;
    end

    assign o_avail     = ~&r_alloc;
    assign o_tag       = w_tag;
    assign o_alloc_vec = r_alloc;
    assign o_count     = w_count;

endmodule

// File: rtl/fpu_issue_scoreboard.sv
// FPU issue stage: RAW/WAW scoreboard, one-entry issue register and tagged
// out-of-order writeback onto the FP register-file write port.
module fpu_issue_scoreboard
    import fpu_issue_pkg::*;
#(
    parameter int FPLEN   = 16,
    parameter int NUM_FPR = 32,
    parameter int MAX_OUT = 4,
    parameter int OPW     = 24
) (
    input  logic                   clk,
    input  logic                   rst_l,
    fpu_issue_scoreboard_if.slave  bus
);

    localparam int AW = $clog2(NUM_FPR);
    localparam int TW = tag_width(MAX_OUT);
    localparam int NT = 1 << TW;    // every value wb_tag can carry

    typedef struct packed {
        logic [OPW-1:0] op;
        iss_ctrl_t      ctrl;
        logic [TW-1:0]  tag;
    } iss_entry_t;

    localparam iss_entry_t ISS_RST = '{op: '0, ctrl: ISS_CTRL_RST, tag: '0};

    logic [MAX_OUT-1:0] w_alloc_vec;
    logic [NT-1:0]      w_alloc_pad;
    logic [NT-1:0]      w_free_pad;
    logic [MAX_OUT-1:0] w_free_mask;
    logic               w_avail;
    logic [TW-1:0]      w_alloc_tag;
    logic [TW:0]        w_count;
    logic [NUM_FPR-1:0] w_busy;
    logic               w_hazard;
    logic               w_accept;
    logic               w_alloc;
    logic               w_wb_hit;
    logic               w_flush_kill;
    logic [FPLEN-1:0]   w_wb_data;
    iss_entry_t         w_iss_load;

    logic [AW-1:0]      r_tag_fd [NT];
    iss_entry_t         r_iss;
    logic               r_iss_valid;
    logic               r_wb_err;

    fpu_tag_alloc #(
        .MAX_OUT (MAX_OUT),
        .TW      (TW)
    ) u_tag_alloc (
        .clk         (clk),
        .rst_l       (rst_l),
        .i_alloc     (w_alloc),
        .i_free_mask (w_free_mask),
        .o_avail     (w_avail),
        .o_tag       (w_alloc_tag),
        .o_alloc_vec (w_alloc_vec),
        .o_count     (w_count)
    );

    // A register is busy while any allocated tag names it as destination.
    always_comb begin
        w_busy = '0;
        for (int t = 0; t < MAX_OUT; t++) begin
            if (w_alloc_vec[t]) w_busy[r_tag_fd[t]] = 1'b1;
        end
    end

    assign w_hazard = (bus.dec_src_en[0] & w_busy[bus.dec_fs1])
                    | (bus.dec_src_en[1] & w_busy[bus.dec_fs2])
                    | (bus.dec_src_en[2] & w_busy[bus.dec_fs3])
                    | (bus.dec_fd_en     & w_busy[bus.dec_fd]);

    assign w_accept = bus.dec_valid & ~bus.flush & ~w_hazard
                    & (~bus.dec_fd_en | w_avail)
                    & (~r_iss_valid | bus.iss_ready);

    assign w_alloc      = w_accept & bus.dec_fd_en;
    assign w_alloc_pad  = NT'(w_alloc_vec);
    assign w_wb_hit     = bus.wb_valid & w_alloc_pad[bus.wb_tag];
    assign w_flush_kill = bus.flush & r_iss_valid & ~bus.iss_ready;

    // Tags released this edge: a valid writeback and/or the flushed un-issued op.
    always_comb begin
        w_free_pad = '0;
        if (w_wb_hit)                        w_free_pad[bus.wb_tag] = 1'b1;
        if (w_flush_kill && r_iss.ctrl.fd_en) w_free_pad[r_iss.tag]  = 1'b1;
    end

    assign w_free_mask = MAX_OUT'(w_free_pad);

    // Entry captured on accept; ops without a destination carry tag 0.
    always_comb begin
        w_iss_load            = ISS_RST;
        w_iss_load.op         = bus.dec_op;
        w_iss_load.ctrl.rnd   = bus.dec_rnd;
        w_iss_load.ctrl.pre   = bus.dec_pre;
        w_iss_load.ctrl.fd_en = bus.dec_fd_en;
        w_iss_load.tag        = bus.dec_fd_en ? w_alloc_tag : '0;
    end

    // Issue register: load on accept, drain on take or flush, otherwise hold.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_iss_valid <= 1'b0;
            r_iss       <= ISS_RST;
        end else if (w_accept) begin
            r_iss_valid <= 1'b1;
            r_iss       <= w_iss_load;
        end else if (bus.iss_ready || bus.flush) begin
            r_iss_valid <= 1'b0;
            r_iss       <= ISS_RST;
        end
    end

    // Destination register recorded against each newly allocated tag.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            // NOTE: this small table is reset so busy_vec and fpr_waddr never show X.
            for (int t = 0; t < NT; t++) r_tag_fd[t] <= {AW{FD_RST}};
        end else if (w_alloc) begin
            r_tag_fd[w_alloc_tag] <= bus.dec_fd;
        end
    end

    // One-cycle error pulse for a writeback to a free tag.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_wb_err <= 1'b0;
        else        r_wb_err <= bus.wb_valid & ~w_wb_hit;
    end

    assign w_wb_data = bus.wb_data;

    assign bus.dec_ready   = w_accept;
    assign bus.iss_valid   = r_iss_valid;
    assign bus.iss_op      = r_iss.op;
    assign bus.iss_rnd     = r_iss.ctrl.rnd;
    assign bus.iss_pre     = r_iss.ctrl.pre;
    assign bus.iss_fd_en   = r_iss.ctrl.fd_en;
    assign bus.iss_tag     = r_iss.tag;
    assign bus.fpr_wen     = w_wb_hit;
    assign bus.fpr_waddr   = r_tag_fd[bus.wb_tag];
    assign bus.fpr_wdata   = w_wb_data;
    assign bus.wb_err      = r_wb_err;
    assign bus.outstanding = w_count;
    assign bus.busy_vec    = w_busy;

endmodule

// File: tb/tb_fpu_issue_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model of tags, destinations and the issue slot.
module tb_fpu_issue_scoreboard;
    import fpu_issue_pkg::*;

    localparam int FPLEN   = 16;
    localparam int NUM_FPR = 32;
    localparam int MAX_OUT = 4;
    localparam int OPW     = 24;
    localparam int AW      = 5;
    localparam int TW      = 2;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    fpu_issue_scoreboard_if #(.FPLEN(FPLEN), .NUM_FPR(NUM_FPR), .MAX_OUT(MAX_OUT), .OPW(OPW)) bus ();

    fpu_issue_scoreboard #(.FPLEN(FPLEN), .NUM_FPR(NUM_FPR), .MAX_OUT(MAX_OUT), .OPW(OPW)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        bit             dv;
        bit [2:0]       src_en;
        int             fs1, fs2, fs3;
        bit             fd_en;
        int             fd;
        logic [OPW-1:0] op;
        logic [2:0]     rnd, pre;
        bit             ir;
        bit             wv;
        int             wt;
        logic [15:0]    wd;
        bit             fl;
    } stim_t;

    stim_t s;

    task automatic idle();
        s.dv = 0; s.src_en = 0; s.fs1 = 0; s.fs2 = 0; s.fs3 = 0;
        s.fd_en = 0; s.fd = 0; s.op = '0; s.rnd = '0; s.pre = '0;
        s.ir = 0; s.wv = 0; s.wt = 0; s.wd = '0; s.fl = 0;
    endtask

    task automatic apply();
        bus.dec_valid  = s.dv;
        bus.dec_src_en = s.src_en;
        bus.dec_fs1    = AW'(s.fs1);
        bus.dec_fs2    = AW'(s.fs2);
        bus.dec_fs3    = AW'(s.fs3);
        bus.dec_fd_en  = s.fd_en;
        bus.dec_fd     = AW'(s.fd);
        bus.dec_op     = s.op;
        bus.dec_rnd    = s.rnd;
        bus.dec_pre    = s.pre;
        bus.iss_ready  = s.ir;
        bus.wb_valid   = s.wv;
        bus.wb_tag     = TW'(s.wt);
        bus.wb_data    = s.wd;
        bus.flush      = s.fl;
    endtask

    // ---------------- reference model ----------------
    bit             m_alloc [MAX_OUT];
    int             m_tfd   [MAX_OUT];
    bit             m_iv;
    logic [OPW-1:0] m_op;
    logic [2:0]     m_rnd, m_pre;
    bit             m_fd_en;
    int             m_tag;
    bit             m_wb_err;
    int             issued_q [$];   // tags the execution unit has taken

    task automatic model_reset();
        for (int t = 0; t < MAX_OUT; t++) begin m_alloc[t] = 0; m_tfd[t] = 0; end
        m_iv = 0; m_op = '0; m_rnd = '0; m_pre = '0; m_fd_en = 0; m_tag = 0;
        m_wb_err = 0;
        issued_q.delete();
    endtask

    function automatic bit m_busy(input int r);
        for (int t = 0; t < MAX_OUT; t++)
            if (m_alloc[t] && m_tfd[t] == r) return 1;
        return 0;
    endfunction

    function automatic logic [NUM_FPR-1:0] m_busy_vec();
        logic [NUM_FPR-1:0] v = '0;
        for (int r = 0; r < NUM_FPR; r++) v[r] = m_busy(r);
        return v;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int t = 0; t < MAX_OUT; t++) c += int'(m_alloc[t]);
        return c;
    endfunction

    function automatic int m_first_free();
        for (int t = 0; t < MAX_OUT; t++) if (!m_alloc[t]) return t;
        return -1;
    endfunction

    function automatic bit m_ready();
        bit haz;
        haz = (s.src_en[0] && m_busy(s.fs1)) || (s.src_en[1] && m_busy(s.fs2)) ||
              (s.src_en[2] && m_busy(s.fs3)) || (s.fd_en && m_busy(s.fd));
        return s.dv && !s.fl && !haz && (!s.fd_en || m_first_free() >= 0) && (!m_iv || s.ir);
    endfunction

    task automatic model_edge(input bit acc);
        bit nxt [MAX_OUT];
        int ft;
        int idx [$];
        nxt = m_alloc;
        m_wb_err = s.wv && !m_alloc[s.wt];
        if (s.wv && m_alloc[s.wt]) begin
            nxt[s.wt] = 0;
            idx = issued_q.find_first_index(x) with (x == s.wt);
            if (idx.size() > 0) issued_q.delete(idx[0]);
        end
        if (m_iv && s.ir && m_fd_en) issued_q.push_back(m_tag);
        if (s.fl && m_iv && !s.ir && m_fd_en) nxt[m_tag] = 0;
        if (acc) begin
            ft = m_first_free();
            if (s.fd_en) begin nxt[ft] = 1; m_tfd[ft] = s.fd; end
            m_iv = 1; m_op = s.op; m_rnd = s.rnd; m_pre = s.pre;
            m_fd_en = s.fd_en; m_tag = s.fd_en ? ft : 0;
        end else if (s.ir || s.fl) begin
            m_iv = 0;
        end
        m_alloc = nxt;
    endtask

    // One clock: drive at negedge, check combinational outputs, clock, check state.
    task automatic step();
        bit exp_ready, exp_wen;
        apply();
        #1;
        exp_ready = m_ready();
        exp_wen   = s.wv && m_alloc[s.wt];
        check("dec_ready", bus.dec_ready, exp_ready);
        check("fpr_wen", bus.fpr_wen, exp_wen);
        if (exp_wen) begin
            check("fpr_waddr", bus.fpr_waddr, m_tfd[s.wt]);
            check("fpr_wdata", bus.fpr_wdata, s.wd);
        end
        @(posedge clk);
        model_edge(exp_ready);
        @(negedge clk);
        check("iss_valid", bus.iss_valid, m_iv);
        if (m_iv) begin
            check("iss_op", bus.iss_op, m_op);
            check("iss_rnd", bus.iss_rnd, m_rnd);
            check("iss_pre", bus.iss_pre, m_pre);
            check("iss_fd_en", bus.iss_fd_en, m_fd_en);
            check("iss_tag", bus.iss_tag, m_tag);
        end
        check("busy_vec", bus.busy_vec, m_busy_vec());
        check("outstanding", bus.outstanding, m_count());
        check("wb_err", bus.wb_err, m_wb_err);
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        idle(); apply(); model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_iss_valid", bus.iss_valid, 0);
        check("rst_iss_op", bus.iss_op, 0);
        check("rst_iss_tag", bus.iss_tag, 0);
        check("rst_busy_vec", bus.busy_vec, 0);
        check("rst_outstanding", bus.outstanding, 0);
        check("rst_wb_err", bus.wb_err, 0);
        rst_l = 1'b1;
    endtask

    task automatic op(input int fd, input bit fd_en, input bit ir);
        idle();
        s.dv = 1; s.fd_en = fd_en; s.fd = fd; s.ir = ir;
        s.op = OPW'(32'h100 + fd); s.rnd = 3'(fd); s.pre = 3'(fd + 1);
    endtask

    initial begin
        idle(); apply();

        // ---- RAW hazard resolved by writeback ----
        do_reset();
        op(3, 1, 1); step();
        op(4, 1, 1); s.src_en = 3'b001; s.fs1 = 3; apply(); #1;
        check("raw_blocked", bus.dec_ready, 0);
        step(); step();
        s.wv = 1; s.wt = 0; s.wd = 16'h3F80; apply(); #1;
        check("raw_wb_wen", bus.fpr_wen, 1);
        check("raw_wb_waddr", bus.fpr_waddr, 3);
        check("raw_wb_wdata", bus.fpr_wdata, 16'h3F80);
        check("raw_wb_still_blocked", bus.dec_ready, 0);
        step();
        s.wv = 0; apply(); #1;
        check("raw_released", bus.dec_ready, 1);
        step();
        check("raw_b_tag", bus.iss_tag, 0);
        check("raw_b_busy", bus.busy_vec, 32'h10);

        // ---- tag exhaustion, no-destination op, same-edge free/alloc ----
        do_reset();
        for (int i = 1; i <= 4; i++) begin op(i, 1, 1); step(); end
        idle(); s.ir = 1; step();
        check("full_outstanding", bus.outstanding, 4);
        op(5, 1, 1); apply(); #1;
        check("full_fd_held", bus.dec_ready, 0);
        step();
        op(0, 0, 1); apply(); #1;
        check("full_store_ok", bus.dec_ready, 1);
        step();
        check("store_fd_en", bus.iss_fd_en, 0);
        check("store_outstanding", bus.outstanding, 4);
        op(6, 1, 1); s.wv = 1; s.wt = 2; s.wd = 16'h4000; apply(); #1;
        check("sameedge_not_ready", bus.dec_ready, 0);
        check("sameedge_waddr", bus.fpr_waddr, 3);
        step();
        s.wv = 0; apply(); #1;
        check("sameedge_ready_next", bus.dec_ready, 1);
        step();
        check("sameedge_tag", bus.iss_tag, 2);
        check("sameedge_outstanding", bus.outstanding, 4);

        // ---- backpressure then flush ----
        do_reset();
        op(7, 1, 0); s.op = 24'h123456; s.rnd = 3'd2; s.pre = 3'd5; step();
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_op_stable", bus.iss_op, 24'h123456);
            check("bp_rnd_stable", bus.iss_rnd, 2);
            check("bp_pre_stable", bus.iss_pre, 5);
        end
        check("bp_outstanding", bus.outstanding, 1);
        s.fl = 1; step();
        check("flush_valid", bus.iss_valid, 0);
        check("flush_busy7", bus.busy_vec[7], 0);
        check("flush_outstanding", bus.outstanding, 0);

        // ---- out-of-order writeback ----
        do_reset();
        op(5, 1, 1); step();
        op(6, 1, 1); step();
        idle(); s.ir = 1; step();
        s.wv = 1; s.wt = 1; s.wd = 16'h1111; apply(); #1;
        check("ooo_first_waddr", bus.fpr_waddr, 6);
        step();
        s.wt = 0; s.wd = 16'h2222; apply(); #1;
        check("ooo_second_waddr", bus.fpr_waddr, 5);
        step();
        idle(); step();
        check("ooo_busy5", bus.busy_vec[5], 0);
        check("ooo_busy6", bus.busy_vec[6], 0);
        check("ooo_outstanding", bus.outstanding, 0);

        // ---- reset mid-flight ----
        do_reset();
        op(1, 1, 1); step();
        op(2, 1, 1); step();
        check("mid_outstanding", bus.outstanding, 2);
        rst_l = 1'b0; idle(); apply(); #1;
        check("mid_rst_busy", bus.busy_vec, 0);
        check("mid_rst_outstanding", bus.outstanding, 0);
        check("mid_rst_valid", bus.iss_valid, 0);
        model_reset();
        @(negedge clk); rst_l = 1'b1;
        s.wv = 1; s.wt = 0; s.wd = 16'hBEEF; apply(); #1;
        check("mid_stale_wen", bus.fpr_wen, 0);
        step();
        check("mid_stale_err", bus.wb_err, 1);
        idle(); step();

        // ---- random traffic ----
        for (int n = 0; n < 600; n++) begin
            idle();
            s.dv     = ($urandom_range(0, 9) < 7);
            s.src_en = 3'($urandom_range(0, 7));
            s.fs1    = $urandom_range(0, 7);
            s.fs2    = $urandom_range(0, 7);
            s.fs3    = $urandom_range(0, 7);
            s.fd_en  = ($urandom_range(0, 3) != 0);
            s.fd     = $urandom_range(0, 7);
            s.op     = OPW'($urandom);
            s.rnd    = 3'($urandom_range(0, 7));
            s.pre    = 3'($urandom_range(0, 7));
            s.ir     = ($urandom_range(0, 9) < 7);
            s.fl     = ($urandom_range(0, 19) == 0);
            s.wd     = 16'($urandom);
            if (issued_q.size() > 0 && $urandom_range(0, 9) < 5) begin
                s.wv = 1;
                s.wt = issued_q[$urandom_range(0, issued_q.size() - 1)];
            end else if ($urandom_range(0, 19) == 0) begin
                s.wv = 1;
                s.wt = $urandom_range(0, MAX_OUT - 1);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
